glitch_sweep_sched: RTL and testbench

Sequencing controller for the glitch generator. It sweeps a two-dimensional grid of glitch delay and pulse-width settings, and fires the glitch engine REPEAT times at each grid point through its trigger/done handshake. After each attempt it waits a bounded time for the target's verdict, then reports every fault or timeout as a logged hit, so an entire fault-injection campaign runs unattended from a single start pulse.

---
 rtl/glitch_sweep_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_glitch_sweep_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_sched.sv
// Glitch campaign sequencer: walks a delay x width grid, fires the glitch engine
// REPEAT times per point, waits for the target verdict and logs faults/timeouts as hits.
module glitch_sweep_sched #(
    parameter int unsigned   DW         = 32,
    parameter logic [DW-1:0] DELAY_MIN  = DW'(0),
    parameter logic [DW-1:0] DELAY_MAX  = DW'(1000),
    parameter logic [DW-1:0] DELAY_STEP = DW'(10),
    parameter logic [DW-1:0] WIDTH_MIN  = DW'(1),
    parameter logic [DW-1:0] WIDTH_MAX  = DW'(200),
    parameter logic [DW-1:0] WIDTH_STEP = DW'(1),
    parameter int unsigned   REPEAT     = 4,
    parameter int unsigned   TIMEOUT    = 100000,
    parameter int unsigned   COOLDOWN   = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic [DW-1:0] eng_delay,
    output logic [DW-1:0] eng_width,
    output logic          eng_trigger,
    input  logic          eng_done,
    input  logic          tgt_valid,
    input  logic          tgt_fault,
    output logic          hit_valid,
    input  logic          hit_ready,
    output logic [DW-1:0] hit_delay,
    output logic [DW-1:0] hit_width,
    output logic          hit_timeout,
    output logic          sweep_done,
    output logic [DW-1:0] attempt_cnt
);

    localparam int unsigned CW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_DONE,
        ST_WAIT_RESULT,
        ST_REPORT,
        ST_COOLDOWN,
        ST_ADVANCE
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            trig_q, trig_d;
    logic            eng_done_q;
    logic [DW-1:0]   delay_q, delay_d;
    logic [DW-1:0]   width_q, width_d;
    logic [DW-1:0]   attempt_q, attempt_d;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic [CW-1:0]   cool_q, cool_d;
    logic [CW-1:0]   rep_q, rep_d;
    logic            hit_valid_q, hit_valid_d;
    logic [DW-1:0]   hit_delay_q, hit_delay_d;
    logic [DW-1:0]   hit_width_q, hit_width_d;
    logic            hit_tmo_q, hit_tmo_d;
    logic            sweep_done_q, sweep_done_d;
    logic [DW:0]     width_sum, delay_sum;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            trig_q       <= 1'b0;
            eng_done_q   <= 1'b0;
            delay_q      <= DELAY_MIN;
            width_q      <= WIDTH_MIN;
            attempt_q    <= '0;
            tmo_q        <= '0;
            cool_q       <= '0;
            rep_q        <= '0;
            hit_valid_q  <= 1'b0;
            hit_delay_q  <= '0;
            hit_width_q  <= '0;
            hit_tmo_q    <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            trig_q       <= trig_d;
            eng_done_q   <= eng_done;
            delay_q      <= delay_d;
            width_q      <= width_d;
            attempt_q    <= attempt_d;
            tmo_q        <= tmo_d;
            cool_q       <= cool_d;
            rep_q        <= rep_d;
            hit_valid_q  <= hit_valid_d;
            hit_delay_q  <= hit_delay_d;
            hit_width_q  <= hit_width_d;
            hit_tmo_q    <= hit_tmo_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        trig_d       = trig_q;
        delay_d      = delay_q;
        width_d      = width_q;
        attempt_d    = attempt_q;
        tmo_d        = tmo_q;
        cool_d       = cool_q;
        rep_d        = rep_q;
        hit_valid_d  = hit_valid_q;
        hit_delay_d  = hit_delay_q;
        hit_width_d  = hit_width_q;
        hit_tmo_d    = hit_tmo_q;
        sweep_done_d = 1'b0;
        // One extra bit so a step past all-ones is seen as overflow, not wrap
        width_sum    = {1'b0, width_q} + {1'b0, WIDTH_STEP};
        delay_sum    = {1'b0, delay_q} + {1'b0, DELAY_STEP};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    delay_d   = DELAY_MIN;
                    width_d   = WIDTH_MIN;
                    attempt_d = '0;
                    rep_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                trig_d = 1'b1;
                if (attempt_q != '1) begin
                    attempt_d = attempt_q + DW'(1);
                end
                rep_d   = rep_q + CW'(1);
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // eng_done is left high by the previous firing, so only a rising edge counts
                if (eng_done && !eng_done_q) begin
                    trig_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_WAIT_RESULT;
                end
            end
            ST_WAIT_RESULT: begin
                if (tgt_valid) begin
                    if (tgt_fault) begin
                        hit_valid_d = 1'b1;
                        hit_delay_d = delay_q;
                        hit_width_d = width_q;
                        hit_tmo_d   = 1'b0;
                        state_d     = ST_REPORT;
                    end else begin
                        cool_d  = '0;
                        state_d = ST_COOLDOWN;
                    end
                end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    hit_valid_d = 1'b1;
                    hit_delay_d = delay_q;
                    hit_width_d = width_q;
                    hit_tmo_d   = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            ST_REPORT: begin
                if (hit_ready) begin
                    hit_valid_d = 1'b0;
                    cool_d      = '0;
                    state_d     = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if ((COOLDOWN == 0) || (cool_q == CW'(COOLDOWN - 1))) begin
                    state_d = ST_ADVANCE;
                end else begin
                    cool_d = cool_q + CW'(1);
                end
            end
            ST_ADVANCE: begin
                if (rep_q < CW'(REPEAT)) begin
                    state_d = ST_ARM;
                end else begin
                    rep_d = '0;
                    if (width_sum > {1'b0, WIDTH_MAX}) begin
                        width_d = WIDTH_MIN;
                        if (delay_sum > {1'b0, DELAY_MAX}) begin
                            sweep_done_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = ST_IDLE;
                        end else begin
                            delay_d = delay_sum[DW-1:0];
                            state_d = ST_ARM;
                        end
                    end else begin
                        width_d = width_sum[DW-1:0];
                        state_d = ST_ARM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops any pending hit and never reports completion
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            trig_d       = 1'b0;
            hit_valid_d  = 1'b0;
            busy_d       = 1'b0;
            sweep_done_d = 1'b0;
        end
    end

    assign busy        = busy_q;
    assign eng_delay   = delay_q;
    assign eng_width   = width_q;
    assign eng_trigger = trig_q;
    assign hit_valid   = hit_valid_q;
    assign hit_delay   = hit_delay_q;
    assign hit_width   = hit_width_q;
    assign hit_timeout = hit_tmo_q;
    assign sweep_done  = sweep_done_q;
    assign attempt_cnt = attempt_q;

endmodule

// File: tb/tb_glitch_sweep_sched.sv
// Scoreboard bench for glitch_sweep_sched: engine/target models drive the handshakes,
// expected triggers and hits are enumerated from the grid when each sweep is started.
module tb_glitch_sweep_sched;

    localparam longint DMIN    = 0;
    localparam longint DMAX    = 25;
    localparam longint DSTEP   = 10;
    localparam longint WMIN    = 64'h0000_0000_FFFF_FFF9;
    localparam longint WMAX    = 64'h0000_0000_FFFF_FFFF;
    localparam longint WSTEP   = 5;
    localparam int     REP     = 2;
    localparam int     TMO     = 20;
    localparam int     COOL    = 3;
    localparam longint FAULT_D = 10;
    localparam int     ENG_LAT = 3;
    localparam int     TGT_LAT = 2;
    localparam int     BOUND   = 5000;

    localparam int TGT_OK    = 0;
    localparam int TGT_FAULT = 1;
    localparam int TGT_NONE  = 2;

    typedef struct packed { logic [31:0] d; logic [31:0] w; logic [31:0] n; } trig_t;
    typedef struct packed { logic [31:0] d; logic [31:0] w; logic tmo; } hit_t;

    logic        clk, rst_n, start, abort, eng_done, tgt_valid, tgt_fault, hit_ready;
    logic        busy, eng_trigger, hit_valid, hit_timeout, sweep_done;
    logic [31:0] eng_delay, eng_width, hit_delay, hit_width, attempt_cnt;

    trig_t trig_q[$];
    hit_t  hit_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    tgt_mode = TGT_OK;
    int    sweep_cnt = 0;
    int    exp_sweeps = 0;
    int    exp_att = 0;
    int    cyc = 0;
    int    t_fall = 0;
    bit    stall_chk = 1'b0;

    glitch_sweep_sched #(
        .DW(32), .DELAY_MIN(32'(DMIN)), .DELAY_MAX(32'(DMAX)), .DELAY_STEP(32'(DSTEP)),
        .WIDTH_MIN(32'(WMIN)), .WIDTH_MAX(32'(WMAX)), .WIDTH_STEP(32'(WSTEP)),
        .REPEAT(REP), .TIMEOUT(TMO), .COOLDOWN(COOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
        .eng_delay(eng_delay), .eng_width(eng_width), .eng_trigger(eng_trigger),
        .eng_done(eng_done), .tgt_valid(tgt_valid), .tgt_fault(tgt_fault),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_delay(hit_delay),
        .hit_width(hit_width), .hit_timeout(hit_timeout), .sweep_done(sweep_done),
        .attempt_cnt(attempt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk_eq({pfx, "_busy"},        64'(busy),        64'(0));
        chk_eq({pfx, "_trigger"},     64'(eng_trigger), 64'(0));
        chk_eq({pfx, "_hit_valid"},   64'(hit_valid),   64'(0));
        chk_eq({pfx, "_hit_timeout"}, 64'(hit_timeout), 64'(0));
        chk_eq({pfx, "_sweep_done"},  64'(sweep_done),  64'(0));
        chk_eq({pfx, "_attempt_cnt"}, 64'(attempt_cnt), 64'(0));
        chk_eq({pfx, "_hit_delay"},   64'(hit_delay),   64'(0));
        chk_eq({pfx, "_hit_width"},   64'(hit_width),   64'(0));
        chk_eq({pfx, "_eng_delay"},   64'(eng_delay),   64'(DMIN));
        chk_eq({pfx, "_eng_width"},   64'(eng_width),   64'(WMIN));
    endtask

    // Enumerate the lattice directly; MAX is included only when it sits on a step
    task automatic push_expect(input int mode);
        int n;
        n = 0;
        for (longint d = DMIN; d <= DMAX; d += DSTEP) begin
            for (longint w = WMIN; w <= WMAX; w += WSTEP) begin
                for (int r = 0; r < REP; r++) begin
                    n++;
                    trig_q.push_back(trig_t'{d: 32'(d), w: 32'(w), n: 32'(n)});
                    if (mode == TGT_NONE)
                        hit_q.push_back(hit_t'{d: 32'(d), w: 32'(w), tmo: 1'b1});
                    else if (mode == TGT_FAULT && d == FAULT_D && w == WMIN)
                        hit_q.push_back(hit_t'{d: 32'(d), w: 32'(w), tmo: 1'b0});
                end
            end
        end
        exp_att = n;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input int mode, input bit stall, input bit dup_start);
        int n;
        tgt_mode = mode;
        push_expect(mode);
        exp_sweeps++;
        if (stall) begin
            hit_ready = 1'b0;
            stall_chk = 1'b1;
        end
        pulse_start();
        if (dup_start) begin
            repeat (30) @(negedge clk);
            pulse_start();
        end
        if (stall) begin
            n = 0;
            while (!hit_valid && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            repeat (5) @(negedge clk);
            hit_ready = 1'b1;
        end
        n = 0;
        while (sweep_cnt < exp_sweeps && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk_eq("sweep_done_seen", 64'(sweep_cnt), 64'(exp_sweeps));
        repeat (3) @(negedge clk);
    endtask

    task automatic abort_test();
        int n;
        int sw0;
        tgt_mode = TGT_OK;
        trig_q.push_back(trig_t'{d: 32'(DMIN), w: 32'(WMIN), n: 32'd1});
        sw0 = sweep_cnt;
        pulse_start();
        n = 0;
        while (!eng_trigger && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("abort_trig_before", 64'(eng_trigger), 64'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #3;
        chk_eq("abort_trigger", 64'(eng_trigger), 64'(0));
        chk_eq("abort_busy",    64'(busy),        64'(0));
        chk_eq("abort_done",    64'(sweep_done),  64'(0));
        repeat (20) @(negedge clk);
        chk_eq("abort_no_sweep_done", 64'(sweep_cnt), 64'(sw0));
        chk_eq("abort_trig_q_empty", 64'(trig_q.size()), 64'(0));
    endtask

    task automatic reset_test();
        int n;
        tgt_mode  = TGT_NONE;
        hit_ready = 1'b0;
        push_expect(TGT_NONE);
        pulse_start();
        n = 0;
        while (!hit_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk_eq("rst_hit_before", 64'(hit_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        trig_q.delete();
        hit_q.delete();
        hit_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Engine: done drops when a firing starts and rises ENG_LAT cycles later
    initial begin : engine_model
        int   cnt;
        logic tp;
        cnt = 0;
        tp  = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_trigger && !tp) begin
                eng_done = 1'b0;
                cnt = ENG_LAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) eng_done = 1'b1;
            end
            tp = eng_trigger;
        end
    end

    // Target: verdict pulse TGT_LAT cycles after the trigger falls, unless silent
    initial begin : target_model
        int   cnt;
        logic tp;
        cnt = 0;
        tp  = 1'b0;
        forever begin
            @(negedge clk);
            tgt_valid = 1'b0;
            tgt_fault = 1'b0;
            if (tp && !eng_trigger && busy && tgt_mode != TGT_NONE) begin
                cnt = TGT_LAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tgt_valid = 1'b1;
                    tgt_fault = (tgt_mode == TGT_FAULT) && (eng_delay == 32'(FAULT_D))
                                && (eng_width == 32'(WMIN));
                end
            end
            tp = eng_trigger;
        end
    end

    initial begin : monitor
        logic        tp, hvp;
        int          hold_len;
        logic [63:0] cap_dw;
        logic        cap_to;
        trig_t       te;
        hit_t        he;
        tp = 1'b0; hvp = 1'b0; hold_len = 0; cap_dw = '0; cap_to = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!rst_n) begin
                tp = 1'b0;
                hvp = 1'b0;
                hold_len = 0;
            end else begin
                if (eng_trigger && !tp) begin
                    chk_eq("trig_pending", 64'(trig_q.size() > 0), 64'(1));
                    if (trig_q.size() > 0) begin
                        te = trig_q.pop_front();
                        chk_eq("trig_delay",   64'(eng_delay),   64'(te.d));
                        chk_eq("trig_width",   64'(eng_width),   64'(te.w));
                        chk_eq("trig_attempt", 64'(attempt_cnt), 64'(te.n));
                    end
                end
                if (!eng_trigger && tp) t_fall = cyc;
                if (hit_valid) begin
                    if (!hvp) begin
                        cap_dw   = {hit_delay, hit_width};
                        cap_to   = hit_timeout;
                        hold_len = 1;
                        if (tgt_mode == TGT_NONE)
                            chk_eq("tmo_latency", 64'(cyc - t_fall), 64'(TMO));
                    end else begin
                        hold_len++;
                        chk_eq("hit_stable_dw", {hit_delay, hit_width}, cap_dw);
                        chk_eq("hit_stable_to", 64'(hit_timeout), 64'(cap_to));
                    end
                    if (hit_ready) begin
                        chk_eq("hit_pending", 64'(hit_q.size() > 0), 64'(1));
                        if (hit_q.size() > 0) begin
                            he = hit_q.pop_front();
                            chk_eq("hit_delay",   64'(hit_delay),   64'(he.d));
                            chk_eq("hit_width",   64'(hit_width),   64'(he.w));
                            chk_eq("hit_timeout", 64'(hit_timeout), 64'(he.tmo));
                        end
                        if (stall_chk) begin
                            chk_eq("hit_hold_len", 64'(hold_len), 64'(6));
                            stall_chk = 1'b0;
                        end
                    end
                end
                if (sweep_done) begin
                    sweep_cnt++;
                    chk_eq("done_busy",        64'(busy),           64'(0));
                    chk_eq("done_attempt_cnt", 64'(attempt_cnt),    64'(exp_att));
                    chk_eq("done_trig_left",   64'(trig_q.size()),  64'(0));
                    chk_eq("done_hit_left",    64'(hit_q.size()),   64'(0));
                end
                tp  = eng_trigger;
                hvp = hit_valid && !hit_ready;
            end
        end
    end

    initial begin : main
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; eng_done = 1'b1;
        tgt_valid = 1'b0; tgt_fault = 1'b0; hit_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(TGT_OK, 1'b0, 1'b1);
        run_sweep(TGT_FAULT, 1'b1, 1'b0);
        run_sweep(TGT_NONE, 1'b0, 1'b0);
        abort_test();
        run_sweep(TGT_OK, 1'b0, 1'b0);
        reset_test();
        run_sweep(TGT_OK, 1'b0, 1'b0);

        chk_eq("total_sweeps", 64'(sweep_cnt), 64'(exp_sweeps));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
